// File: rtl/inst_cache_pkg.sv
// Shared constants and types for the instruction cache.
// Default geometry: 64 lines of 4 words over an 18-bit byte address.
package inst_cache_pkg;

    localparam int DATA_W            = 32;
    localparam int ADDR_W            = 18;
    localparam int WADDR_W           = ADDR_W - 2;
    localparam int ICACHE_INDEX_BITS = 6;
    localparam int ICACHE_LINE_LOG   = 2;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    typedef logic [WADDR_W-1:0] waddr_t;

endpackage

// File: rtl/inst_cache_if.sv
// Fetcher request/response and memory-controller word bus.
// slave = cache side, master = fetcher/memory side.
interface inst_cache_if;
    import inst_cache_pkg::*;

    logic [31:0]       addr;
    logic              rn;
    logic [DATA_W-1:0] Inst;
    logic              Read_ready;
    logic              mem_req;
    waddr_t            mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;

    modport slave (
        input  addr, rn, mem_data, mem_ack,
        output Inst, Read_ready, mem_req, mem_addr
    );

    modport master (
        output addr, rn, mem_data, mem_ack,
        input  Inst, Read_ready, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_line_ram.sv
// Cache data array: synchronous write, asynchronous read.
// Depth is 2**DEPTH_LOG words.
module icache_line_ram #(
    parameter int DEPTH_LOG = 8,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [DEPTH_LOG-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// Define ICACHE_BYPASS_EN to drop the arrays and fetch each word directly.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int LINE_LOG   = ICACHE_LINE_LOG
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    inst_cache_if.slave bus
);

    state_t            state;
    logic [DATA_W-1:0] inst_q;
    logic              rr_q;
    logic              req_q;
    waddr_t            maddr_q;
    waddr_t            in_w;
    logic              ack;
    logic              take;
    logic              unused_bits;

    assign in_w        = bus.addr[ADDR_W-1:2];
    assign ack         = bus.mem_ack && req_q;
    // a request seen on the Read_ready edge is the stale one
    assign take        = bus.rn && !rr_q;
    assign unused_bits = ^{bus.addr[31:ADDR_W], bus.addr[1:0]};

    assign bus.Inst       = inst_q;
    assign bus.Read_ready = rr_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = maddr_q;

`ifdef ICACHE_BYPASS_EN

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            inst_q  <= '0;
            rr_q    <= 1'b0;
            req_q   <= 1'b0;
            maddr_q <= '0;
        end else if (rdy) begin
            rr_q <= 1'b0;
            unique case (state)
                IDLE: if (take) begin
                    req_q   <= 1'b1;
                    maddr_q <= in_w;
                    state   <= REFILL;
                end
                REFILL: if (ack) begin
                    inst_q <= bus.mem_data;
                    req_q  <= 1'b0;
                    rr_q   <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

`else

    localparam int TAG_BITS = WADDR_W - INDEX_BITS - LINE_LOG;
    localparam int LINES    = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [LINE_LOG-1:0]   cnt;
    waddr_t                req_addr;
    logic [TAG_BITS-1:0]   in_tag, r_tag;
    logic [INDEX_BITS-1:0] in_idx, r_idx;
    logic [LINE_LOG-1:0]   in_off, r_off;
    logic [DATA_W-1:0]     rd_data;
    logic                  hit;
    logic                  we;

    assign {in_tag, in_idx, in_off} = in_w;
    assign {r_tag, r_idx, r_off}    = req_addr;
    assign hit = valid[in_idx] && (tags[in_idx] == in_tag);
    assign we  = rdy && (state == REFILL) && ack;

    icache_line_ram #(
        .DEPTH_LOG (INDEX_BITS + LINE_LOG),
        .WIDTH     (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr ({r_idx, cnt}),
        .wdata (bus.mem_data),
        .raddr ({in_idx, in_off}),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            inst_q   <= '0;
            rr_q     <= 1'b0;
            req_q    <= 1'b0;
            maddr_q  <= '0;
            cnt      <= '0;
            req_addr <= '0;
        end else if (rdy) begin
            rr_q <= 1'b0;
            unique case (state)
                IDLE: if (take) begin
                    req_addr <= in_w;
                    if (hit) begin
                        inst_q <= rd_data;
                        rr_q   <= 1'b1;
                    end else begin
                        valid[in_idx] <= 1'b0;
                        req_q   <= 1'b1;
                        maddr_q <= {in_tag, in_idx, {LINE_LOG{1'b0}}};
                        cnt     <= '0;
                        state   <= REFILL;
                    end
                end
                REFILL: if (ack) begin
                    if (cnt == r_off) inst_q <= bus.mem_data;
                    cnt     <= cnt + 1'b1;
                    maddr_q <= maddr_q + 1'b1;
                    if (&cnt) begin
                        tags[r_idx]  <= r_tag;
                        valid[r_idx] <= 1'b1;
                        req_q <= 1'b0;
                        rr_q  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_inst_cache.sv
// Randomised bench for inst_cache against a line-level cache model.
// Memory contents come from a fixed word function plus overrides.
module tb_inst_cache;
    import inst_cache_pkg::*;

`ifdef ICACHE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    inst_cache_if bus ();

    inst_cache dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int rr_cnt = 0;
    int ack_pct = 100;
    bit spurious = 1'b0;
    logic [15:0] hs_q [$];
    logic [31:0] mem_ovr [int];
    int model_tag [int];

    function automatic logic [31:0] memword(input logic [15:0] w);
        if (mem_ovr.exists(int'(w))) return mem_ovr[int'(w)];
        return {w ^ 16'h5A3C, ~w};
    endfunction

    // line-level cache model: returns hit and records the line as resident
    function automatic bit model_access(input logic [31:0] a);
        logic [15:0] w;
        int idx;
        int tag;
        bit hit;
        w   = a[17:2];
        idx = int'(w[7:2]);
        tag = int'(w[15:8]);
        hit = !BYPASS && model_tag.exists(idx) && model_tag[idx] == tag;
        if (!BYPASS) model_tag[idx] = tag;
        return hit;
    endfunction

    function automatic int exp_acks(input bit hit);
        return hit ? 0 : (BYPASS ? 1 : 4);
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.mem_ack = 1'b0;
        end else if (bus.mem_req && $urandom_range(99) < ack_pct) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = memword(bus.mem_addr);
        end else if (!bus.mem_req && spurious && $urandom_range(3) == 0) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = $urandom;
        end else begin
            bus.mem_ack  = 1'b0;
            bus.mem_data = $urandom;
        end
    end

    always @(posedge clk) begin
        if (!rst && rdy && bus.mem_req && bus.mem_ack) begin
            ack_cnt++;
            hs_q.push_back(bus.mem_addr);
        end
    end

    always @(negedge clk) begin
        if (bus.Read_ready) rr_cnt++;
    end

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] d,
                            output int acks, output int cyc, output bit ok);
        int a0;
        a0 = ack_cnt;
        bus.addr = a;
        bus.rn = 1'b1;
        cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 300) begin
            @(negedge clk);
            cyc++;
            ok = bus.Read_ready;
        end
        d = bus.Inst;
        acks = ack_cnt - a0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        bus.rn = 1'b0;
        bus.addr = '0;
        bus.mem_ack = 1'b0;
        bus.mem_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.Read_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_rr got %b want 0", bus.Read_ready);
        end
        checks++;
        if (bus.Inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_inst got %h want 0", bus.Inst);
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_req got %b want 0", bus.mem_req);
        end
        checks++;
        if (bus.mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr);
        end
        rst = 1'b0;
        model_tag.delete();
        @(negedge clk);
        hs_q.delete();
    endtask

    task automatic test_first_miss();
        logic [31:0] d;
        int acks, cyc, n;
        bit ok, hit, bad;
        mem_ovr[0] = 32'h11;
        mem_ovr[1] = 32'h22;
        mem_ovr[2] = 32'h33;
        mem_ovr[3] = 32'h44;
        ack_pct = 100;
        hs_q.delete();
        hit = model_access(32'h0);
        do_fetch(32'h0, d, acks, cyc, ok);
        bus.rn = 1'b0;
        checks++;
        if (!ok || d !== memword(16'h0)) begin
            errors++;
            $display("FAIL miss_inst got %h ok %b want %h", d, ok, memword(16'h0));
        end
        checks++;
        if (acks != exp_acks(hit)) begin
            errors++;
            $display("FAIL miss_acks got %0d want %0d", acks, exp_acks(hit));
        end
        checks++;
        if (cyc != (BYPASS ? 2 : 5)) begin
            errors++;
            $display("FAIL miss_latency got %0d want %0d", cyc, BYPASS ? 2 : 5);
        end
        n = BYPASS ? 1 : 4;
        bad = (hs_q.size() != n);
        for (int i = 0; i < hs_q.size() && i < n; i++)
            if (hs_q[i] !== 16'(i)) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL miss_mem_addr got %0d words first %h want %0d from 0",
                     hs_q.size(), hs_q.size() ? hs_q[0] : 16'hxxxx, n);
        end
        @(negedge clk);
        checks++;
        if (bus.Read_ready !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL miss_single_pulse got rr %b req %b want 0 0",
                     bus.Read_ready, bus.mem_req);
        end
    endtask

    task automatic test_hit();
        logic [31:0] d;
        int acks, cyc;
        bit ok, hit;
        hit = model_access(32'h8);
        do_fetch(32'h8, d, acks, cyc, ok);
        bus.rn = 1'b0;
        checks++;
        if (!ok || d !== 32'h33) begin
            errors++;
            $display("FAIL hit_inst got %h ok %b want 33", d, ok);
        end
        checks++;
        if (acks != exp_acks(hit)) begin
            errors++;
            $display("FAIL hit_acks got %0d want %0d", acks, exp_acks(hit));
        end
        checks++;
        if (cyc != (hit ? 1 : 2)) begin
            errors++;
            $display("FAIL hit_latency got %0d want %0d", cyc, hit ? 1 : 2);
        end
        @(negedge clk);
    endtask

    task automatic test_evict();
        logic [31:0] d;
        logic [31:0] seq [2];
        int acks, cyc;
        bit ok, hit;
        seq[0] = 32'h400;
        seq[1] = 32'h0;
        foreach (seq[i]) begin
            hit = model_access(seq[i]);
            do_fetch(seq[i], d, acks, cyc, ok);
            checks++;
            if (!ok || d !== memword(seq[i][17:2])) begin
                errors++;
                $display("FAIL evict_inst[%0d] got %h want %h", i, d,
                         memword(seq[i][17:2]));
            end
            checks++;
            if (acks != exp_acks(hit)) begin
                errors++;
                $display("FAIL evict_acks[%0d] got %0d want %0d", i, acks,
                         exp_acks(hit));
            end
        end
        bus.rn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rdy_stall();
        logic [31:0] a;
        logic [15:0] ma0, want_ma;
        int a0, cyc, stall_at;
        bit ok, hit;
        a = 32'h1234;
        stall_at = BYPASS ? 0 : 2;
        want_ma = BYPASS ? a[17:2] : (a[17:2] & 16'hFFFC) + 16'(stall_at);
        ack_pct = 100;
        hit = model_access(a);
        a0 = ack_cnt;
        bus.addr = a;
        bus.rn = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((ack_cnt - a0) < stall_at && cyc < 50);
        ma0 = bus.mem_addr;
        checks++;
        if (ma0 !== want_ma || hit) begin
            errors++;
            $display("FAIL stall_entry got %h want %h", ma0, want_ma);
        end
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mem_addr !== ma0 || bus.mem_req !== 1'b1 || bus.Read_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got addr %h req %b rr %b want %h 1 0",
                     bus.mem_addr, bus.mem_req, bus.Read_ready, ma0);
        end
        rdy = 1'b1;
        cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 300) begin
            @(negedge clk);
            cyc++;
            ok = bus.Read_ready;
        end
        bus.rn = 1'b0;
        checks++;
        if (!ok || bus.Inst !== memword(a[17:2])) begin
            errors++;
            $display("FAIL stall_inst got %h ok %b want %h", bus.Inst, ok,
                     memword(a[17:2]));
        end
        checks++;
        if ((ack_cnt - a0) != exp_acks(1'b0)) begin
            errors++;
            $display("FAIL stall_acks got %0d want %0d", ack_cnt - a0,
                     exp_acks(1'b0));
        end
        @(negedge clk);
    endtask

    task automatic run_stream(input string nm, input int n, input bit gaps);
        logic [31:0] a, d;
        logic [7:0] t;
        logic [5:0] ix;
        logic [1:0] o;
        int acks, cyc, rr0;
        bit ok, hit;
        rr0 = rr_cnt;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(1) == 1) begin
                bus.rn = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            t  = 8'($urandom_range(gaps ? 3 : 1));
            ix = 6'($urandom_range(gaps ? 7 : 3));
            o  = 2'($urandom_range(3));
            a  = $urandom;
            a[17:2] = {t, ix, o};
            hit = model_access(a);
            do_fetch(a, d, acks, cyc, ok);
            checks++;
            if (!ok || d !== memword(a[17:2])) begin
                errors++;
                $display("FAIL %s_inst[%0d] addr %h got %h want %h", nm, i, a,
                         d, memword(a[17:2]));
            end
            checks++;
            if (acks != exp_acks(hit)) begin
                errors++;
                $display("FAIL %s_acks[%0d] addr %h got %0d want %0d", nm, i,
                         a, acks, exp_acks(hit));
            end
        end
        bus.rn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rr_cnt - rr0 != n) begin
            errors++;
            $display("FAIL %s_pulses got %0d want %0d", nm, rr_cnt - rr0, n);
        end
    endtask

    task automatic test_back_to_back();
        ack_pct = 60;
        run_stream("b2b", 40, 1'b0);
    endtask

    task automatic test_random();
        ack_pct = 40;
        spurious = 1'b1;
        run_stream("rand", 30, 1'b1);
        spurious = 1'b0;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] a, d;
        int acks, cyc;
        bit ok, hit;
        ack_pct = 100;
        a = {14'd0, 8'h55, 6'd9, 2'd1, 2'b00};
        hit = model_access(a);
        bus.addr = a;
        bus.rn = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.mem_req && cyc < 50);
        if (!BYPASS) @(negedge clk);
        rst = 1'b1;
        bus.rn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || bus.Read_ready !== 1'b0 || hit) begin
            errors++;
            $display("FAIL abort got req %b rr %b want 0 0", bus.mem_req,
                     bus.Read_ready);
        end
        rst = 1'b0;
        model_tag.delete();
        @(negedge clk);
        hit = model_access(32'h8);
        do_fetch(32'h8, d, acks, cyc, ok);
        bus.rn = 1'b0;
        checks++;
        if (!ok || d !== 32'h33) begin
            errors++;
            $display("FAIL post_abort_inst got %h want 33", d);
        end
        checks++;
        if (acks != exp_acks(hit)) begin
            errors++;
            $display("FAIL post_abort_acks got %0d want %0d", acks, exp_acks(hit));
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_miss();
        test_hit();
        test_evict();
        test_rdy_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
